// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: runs the reset/enable handshake through the byte-level transceiver,
// then turns 3-byte movement packets into a clamped cursor position and button state.
module ps2_mouse_ctrl #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int RETRY_MAX   = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] tx_byte,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] buttons,
  output logic       pkt_valid,
  output logic       ready,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam int RW = $clog2(RETRY_MAX + 1);

  typedef enum logic [3:0] {
    SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2,
    S_B0, S_B1, S_B2, UPDATE, FAIL
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic [RW-1:0]   retry_r, retry_inc_s;
  logic            fail_s, timeout_s, counting_s, tx_go_s;
  logic [7:0]      tx_val_s;
  logic [6:0]      hdr_r;  // {Yovf, Xovf, Ysign, Xsign, M, R, L}
  logic [7:0]      dx_r, dy_r;
  logic [11:0]     dx_s, dy_s, nx_s, ny_s;
  logic [9:0]      new_x_s, new_y_s;
  logic [9:0]      pos_x_r, pos_y_r;
  logic [2:0]      buttons_r;
  logic [7:0]      tx_byte_r;
  logic            tx_start_r, pkt_valid_r, ready_r, err_r;

  function automatic logic [7:0] wait_exp(input state_t st);
    case (st)
      WAIT_ACK1: wait_exp = 8'hFA;
      WAIT_BAT:  wait_exp = 8'hAA;
      WAIT_ID:   wait_exp = 8'h00;
      WAIT_ACK2: wait_exp = 8'hFA;
      default:   wait_exp = 8'hFA;
    endcase
  endfunction

  function automatic state_t wait_next(input state_t st);
    case (st)
      WAIT_ACK1: wait_next = WAIT_BAT;
      WAIT_BAT:  wait_next = WAIT_ID;
      WAIT_ID:   wait_next = SEND_EN;
      WAIT_ACK2: wait_next = S_B0;
      default:   wait_next = SEND_RST;
    endcase
  endfunction

  assign timeout_s   = (cnt_r == CW'(TIMEOUT_CYC - 1));
  assign retry_inc_s = retry_r + RW'(1);

  // Next-state, command issue and init-failure decision
  always_comb begin
    state_s  = state_r;
    fail_s   = 1'b0;
    tx_go_s  = 1'b0;
    tx_val_s = 8'h00;
    case (state_r)
      SEND_RST, SEND_EN: begin
        if (!tx_busy) begin
          tx_go_s  = 1'b1;
          tx_val_s = (state_r == SEND_RST) ? 8'hFF : 8'hF4;
          state_s  = (state_r == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
        end else begin
          state_s = state_r;
        end
      end
      WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
        if (rx_valid && (rx_byte == wait_exp(state_r))) begin
          state_s = wait_next(state_r);
        end else if (rx_valid || timeout_s) begin
          fail_s  = 1'b1;
          state_s = (retry_inc_s == RW'(RETRY_MAX)) ? FAIL : SEND_RST;
        end else begin
          state_s = state_r;
        end
      end
      S_B0: begin
        if (rx_valid && rx_byte[3]) state_s = S_B1;
        else                        state_s = S_B0;
      end
      S_B1, S_B2: begin
        if (rx_valid)       state_s = (state_r == S_B1) ? S_B2 : UPDATE;
        else if (timeout_s) state_s = S_B0;
        else                state_s = state_r;
      end
      UPDATE:  state_s = S_B0;
      FAIL:    state_s = FAIL;
      default: state_s = SEND_RST;
    endcase
  end

  // Timeout counter runs only while a response or the next packet byte is awaited
  always_comb begin
    case (state_r)
      WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2, S_B1, S_B2: counting_s = 1'b1;
      default:                                             counting_s = 1'b0;
    endcase
  end

  // Signed 12-bit integration of the packet deltas with per-axis clamping
  always_comb begin
    dx_s = hdr_r[5] ? 12'd0 : {{4{hdr_r[3]}}, dx_r};
    dy_s = hdr_r[6] ? 12'd0 : {{4{hdr_r[4]}}, dy_r};
    nx_s = {2'b00, pos_x_r} + dx_s;
    ny_s = {2'b00, pos_y_r} - dy_s;
    if (nx_s[11])                           new_x_s = 10'd0;
    else if (nx_s > 12'(SCREEN_W - 1))      new_x_s = 10'(SCREEN_W - 1);
    else                                    new_x_s = nx_s[9:0];
    if (ny_s[11])                           new_y_s = 10'd0;
    else if (ny_s > 12'(SCREEN_H - 1))      new_y_s = 10'(SCREEN_H - 1);
    else                                    new_y_s = ny_s[9:0];
  end

  // State, counters, packet capture and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= SEND_RST;
      cnt_r       <= '0;
      retry_r     <= '0;
      hdr_r       <= 7'd0;
      dx_r        <= 8'h00;
      dy_r        <= 8'h00;
      pos_x_r     <= 10'(SCREEN_W / 2);
      pos_y_r     <= 10'(SCREEN_H / 2);
      buttons_r   <= 3'd0;
      tx_byte_r   <= 8'h00;
      tx_start_r  <= 1'b0;
      pkt_valid_r <= 1'b0;
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_s != state_r) || rx_valid || !counting_s) cnt_r <= '0;
      else                                                 cnt_r <= cnt_r + CW'(1);
      if (fail_s) retry_r <= retry_inc_s;
      if (state_r == S_B0 && rx_valid && rx_byte[3]) hdr_r <= {rx_byte[7:4], rx_byte[2:0]};
      if (state_r == S_B1 && rx_valid) dx_r <= rx_byte;
      if (state_r == S_B2 && rx_valid) dy_r <= rx_byte;
      if (state_r == UPDATE) begin
        pos_x_r   <= new_x_s;
        pos_y_r   <= new_y_s;
        buttons_r <= hdr_r[2:0];
      end
      tx_start_r <= tx_go_s;
      if (tx_go_s) tx_byte_r <= tx_val_s;
      pkt_valid_r <= (state_r == UPDATE);
      ready_r     <= (state_s == S_B0) || (state_s == S_B1) ||
                     (state_s == S_B2) || (state_s == UPDATE);
      err_r       <= (state_s == FAIL);
    end
  end

  assign tx_byte   = tx_byte_r;
  assign tx_start  = tx_start_r;
  assign pos_x     = pos_x_r;
  assign pos_y     = pos_y_r;
  assign buttons   = buttons_r;
  assign pkt_valid = pkt_valid_r;
  assign ready     = ready_r;
  assign err       = err_r;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init handshake, packet decode, clamping, resync,
// mid-operation reset and retry exhaustion, with hand-computed expectations.
module tb_ps2_mouse_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [9:0] pos_x, pos_y;
  logic [2:0] buttons;
  logic       pkt_valid, ready, err;

  int checks = 0;
  int fails  = 0;
  int tx_cnt = 0;
  int pkt_cnt = 0;
  int consec_err = 0;
  logic prev_tx = 1'b0;

  ps2_mouse_ctrl #(.TIMEOUT_CYC(40)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .pos_x(pos_x), .pos_y(pos_y),
    .buttons(buttons), .pkt_valid(pkt_valid), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts tx_start/pkt_valid pulses and flags back-to-back tx_start
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_cnt = tx_cnt + 1;
      if (prev_tx === 1'b1) consec_err = consec_err + 1;
    end
    prev_tx = tx_start;
    if (pkt_valid === 1'b1) pkt_cnt = pkt_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_byte = 8'h00;
  endtask

  task automatic wait_tx(input logic [7:0] exp_b, input string name);
    int n = 0;
    @(negedge clk);
    while (tx_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_start !== 1'b1) begin
      fails++; $display("FAIL %s: no tx_start within 200 cycles, required byte %h", name, exp_b);
    end else if (tx_byte !== exp_b) begin
      fails++; $display("FAIL %s: tx_byte=%h required %h", name, tx_byte, exp_b);
    end
  endtask

  task automatic do_init(input string name);
    wait_tx(8'hFF, {name, "_ff"});
    send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00);
    wait_tx(8'hF4, {name, "_f4"});
    send_rx(8'hFA);
    checks++;
    if (ready !== 1'b1 || err !== 1'b0) begin
      fails++; $display("FAIL %s_ready: ready=%b err=%b required ready=1 err=0", name, ready, err);
    end
  endtask

  task automatic do_pkt(input logic [7:0] b0, b1, b2, input logic [9:0] ex, ey,
                        input logic [2:0] eb, input string name);
    send_rx(b0); tick(2);
    send_rx(b1); tick(2);
    @(negedge clk);
    rx_byte = b2; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_byte = 8'h00;
    checks++;
    if (pkt_valid !== 1'b0) begin
      fails++; $display("FAIL %s_early: pkt_valid=%b one cycle after byte 3, required 0", name, pkt_valid);
    end
    @(negedge clk);
    checks++;
    if (pkt_valid !== 1'b1) begin
      fails++; $display("FAIL %s_pv: pkt_valid=%b two cycles after byte 3, required 1", name, pkt_valid);
    end
    checks++;
    if ({pos_x, pos_y, buttons} !== {ex, ey, eb}) begin
      fails++; $display("FAIL %s_pos: pos=(%0d,%0d) btn=%b required (%0d,%0d) btn=%b",
                        name, pos_x, pos_y, buttons, ex, ey, eb);
    end
    @(negedge clk);
    checks++;
    if (pkt_valid !== 1'b0) begin
      fails++; $display("FAIL %s_pulse: pkt_valid=%b after pulse, required 0", name, pkt_valid);
    end
  endtask

  task automatic test_reset();
    int base;
    tick(3);
    checks++;
    if ({pos_x, pos_y, buttons, pkt_valid, ready, err, tx_start, tx_byte} !==
        {10'd320, 10'd240, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fails++; $display("FAIL reset_vals: pos=(%0d,%0d) btn=%b pv=%b rdy=%b err=%b txs=%b txb=%h required (320,240) all zero",
                        pos_x, pos_y, buttons, pkt_valid, ready, err, tx_start, tx_byte);
    end
    base = tx_cnt;
    rst = 1'b0;
    tick(6);
    checks++;
    if (tx_cnt != base) begin
      fails++; $display("FAIL busy_gate: %0d tx_start pulses while tx_busy=1, required 0", tx_cnt - base);
    end
    tx_busy = 1'b0;
  endtask

  task automatic test_init();
    int base = tx_cnt;
    do_init("init");
    tick(5);
    checks++;
    if (tx_cnt - base != 2) begin
      fails++; $display("FAIL init_count: %0d tx_start pulses, required 2", tx_cnt - base);
    end
  endtask

  task automatic test_packets();
    do_pkt(8'h09, 8'h05, 8'h03, 10'd325, 10'd237, 3'b001, "pkt1");
    do_pkt(8'h38, 8'hF6, 8'hFE, 10'd315, 10'd239, 3'b000, "pkt2");
  endtask

  task automatic test_clamp();
    do_pkt(8'h18, 8'h00, 8'hED, 10'd59,  10'd2, 3'b000, "move_a");
    do_pkt(8'h18, 8'hCA, 8'h00, 10'd5,   10'd2, 3'b000, "move_b");
    do_pkt(8'h18, 8'h80, 8'h00, 10'd0,   10'd2, 3'b000, "clamp_x0");
    do_pkt(8'h08, 8'h00, 8'h7F, 10'd0,   10'd0, 3'b000, "clamp_y0");
    do_pkt(8'h08, 8'h00, 8'h7F, 10'd0,   10'd0, 3'b000, "clamp_y0_again");
    do_pkt(8'h4F, 8'h50, 8'h00, 10'd0,   10'd0, 3'b111, "x_ovf");
    do_pkt(8'h08, 8'hFF, 8'h00, 10'd255, 10'd0, 3'b000, "right_1");
    do_pkt(8'h08, 8'hFF, 8'h00, 10'd510, 10'd0, 3'b000, "right_2");
    do_pkt(8'h08, 8'hFF, 8'h00, 10'd639, 10'd0, 3'b000, "right_edge");
    do_pkt(8'h08, 8'hFF, 8'h00, 10'd639, 10'd0, 3'b000, "right_hold");
    do_pkt(8'h28, 8'h00, 8'h00, 10'd639, 10'd256, 3'b000, "down_1");
    do_pkt(8'h28, 8'h00, 8'h00, 10'd639, 10'd479, 3'b000, "bottom_edge");
  endtask

  task automatic test_resync();
    int base = pkt_cnt;
    send_rx(8'h00); tick(2);
    send_rx(8'h08); tick(2);
    send_rx(8'h01);
    tick(60);
    checks++;
    if (pkt_cnt != base) begin
      fails++; $display("FAIL resync_drop: %0d pkt_valid pulses, required 0", pkt_cnt - base);
    end
    do_pkt(8'h18, 8'hFE, 8'h00, 10'd637, 10'd479, 3'b000, "after_timeout");
  endtask

  task automatic test_reset_mid();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    wait_tx(8'hFF, "rst_bat_ff");
    send_rx(8'hFA);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pos_x, pos_y, buttons, pkt_valid, ready, err, tx_start, tx_byte} !==
        {10'd320, 10'd240, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fails++; $display("FAIL rst_bat_vals: pos=(%0d,%0d) btn=%b rdy=%b err=%b txb=%h required reset values",
                        pos_x, pos_y, buttons, ready, err, tx_byte);
    end
    rst = 1'b0;
    do_init("rst_bat_init");
    do_pkt(8'h09, 8'h05, 8'h03, 10'd325, 10'd237, 3'b001, "rst_pkt");
    send_rx(8'h0F); tick(2);
    send_rx(8'h20);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pos_x, pos_y, buttons, pkt_valid, ready, err} !==
        {10'd320, 10'd240, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL rst_pkt_vals: pos=(%0d,%0d) btn=%b pv=%b rdy=%b err=%b required (320,240) zeros",
                        pos_x, pos_y, buttons, pkt_valid, ready, err);
    end
    rst = 1'b0;
    do_init("rst_pkt_init");
    do_pkt(8'h09, 8'h05, 8'h03, 10'd325, 10'd237, 3'b001, "rst_clean_pkt");
  endtask

  task automatic test_retry_fail();
    int base;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    base = tx_cnt;
    wait_tx(8'hFF, "retry_ff1");
    send_rx(8'hFE);
    wait_tx(8'hFF, "retry_ff2");
    wait_tx(8'hFF, "retry_ff3_timeout");
    send_rx(8'hFE);
    tick(3);
    checks++;
    if (err !== 1'b1 || ready !== 1'b0) begin
      fails++; $display("FAIL fail_flags: err=%b ready=%b required err=1 ready=0", err, ready);
    end
    checks++;
    if (tx_cnt - base != 3) begin
      fails++; $display("FAIL retry_count: %0d tx_start pulses, required 3", tx_cnt - base);
    end
    send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h00); send_rx(8'hFA);
    tick(50);
    checks++;
    if (tx_cnt - base != 3 || err !== 1'b1) begin
      fails++; $display("FAIL fail_sticky: %0d tx_start pulses err=%b, required 3 and err=1", tx_cnt - base, err);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_packets();
    test_clamp();
    test_resync();
    test_reset_mid();
    test_retry_fail();
    checks++;
    if (consec_err != 0) begin
      fails++; $display("FAIL tx_back_to_back: %0d consecutive tx_start cycles, required 0", consec_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_ctrl.md
Name: ps2_mouse_ctrl

Overview:
Sequences the PS/2 mouse transceiver from power-up to streaming mode.
- Init: sends Reset (0xFF), checks ACK/BAT/ID, then sends Enable Data Reporting (0xF4) and checks its ACK.
- Streaming: assembles 3-byte movement packets and integrates them into a clamped screen cursor position and button state for the graphics/CPU side.
- Sits between the byte-level PS/2 transceiver and the I/O register file.

Parameters:
SCREEN_W, 640, horizontal range; pos_x is clamped to 0..SCREEN_W-1.
SCREEN_H, 480, vertical range; pos_y is clamped to 0..SCREEN_H-1.
TIMEOUT_CYC, 2000000, clk cycles allowed for any awaited response byte, and for the gap between packet bytes.
RETRY_MAX, 3, number of init attempts before declaring failure.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_byte  out  8  command byte to transceiver; held stable while tx_start is high
tx_start  out  1  one-cycle pulse requesting transmission; asserted only when tx_busy=0
tx_busy  in  1  transceiver is sending
rx_byte  in  8  received byte; valid only with rx_valid
rx_valid  in  1  one-cycle pulse per received byte
pos_x  out  10  cursor X
pos_y  out  10  cursor Y, 0 = top of screen
buttons  out  3  {middle, right, left}; 1 = pressed
pkt_valid  out  1  one-cycle pulse when pos/buttons update
ready  out  1  high once streaming mode is entered
err  out  1  sticky init failure flag

Behaviour:
- Reset values: pos_x=SCREEN_W/2 (320), pos_y=SCREEN_H/2 (240), buttons=0, pkt_valid=0, ready=0, err=0, tx_start=0, tx_byte=0x00, retry count=0, state=SEND_RST.
- A synchronous rst also aborts any in-flight command or packet.
- One timeout counter:
  - cleared on every state change and on every rx_valid;
  - counts in all WAIT_* states, and in S_B1/S_B2;
  - "timeout" means the counter reaches TIMEOUT_CYC-1.
- Init states:
  - SEND_RST: when tx_busy=0, pulse tx_start with tx_byte=0xFF -> WAIT_ACK1.
  - WAIT_ACK1: rx 0xFA -> WAIT_BAT.
  - WAIT_BAT: rx 0xAA -> WAIT_ID.
  - WAIT_ID: rx 0x00 -> SEND_EN.
  - SEND_EN: when tx_busy=0, pulse tx_start with tx_byte=0xF4 -> WAIT_ACK2.
  - WAIT_ACK2: rx 0xFA -> S_B0 and set ready=1.
- Failure in any WAIT_* state = wrong byte received, or timeout.
  - Increment the retry count.
  - If the count is now RETRY_MAX -> FAIL; otherwise -> SEND_RST.
  - FAIL: err=1, ready=0, all rx ignored; leave only via rst.
- rx_valid in SEND_* states is ignored.
- tx_start is never asserted in consecutive cycles.
- Stream states:
  - S_B0: accept rx_byte only if bit3=1, latch as b0 -> S_B1. A byte with bit3=0 is discarded and the state stays S_B0 (resync).
  - S_B1: latch dx byte -> S_B2.
  - S_B2: latch dy byte -> UPDATE.
  - Timeout in S_B1 or S_B2 -> S_B0; the partial packet is dropped and there is no pkt_valid.
  - UPDATE (one cycle): registers update, pkt_valid=1 -> S_B0. rx_valid in this cycle is lost; the device spaces its bytes far wider than one cycle.
- Update latency: pos/buttons/pkt_valid change on the 2nd clk edge after the rx_valid of byte 3.
- Arithmetic:
  - b0 fields: [0]=L, [1]=R, [2]=M, [4]=X sign, [5]=Y sign, [6]=X overflow, [7]=Y overflow.
  - dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
  - If an axis overflow bit is set, that axis delta is forced to 0; buttons still update.
  - Compute in signed 12-bit: nx = pos_x + dx, ny = pos_y - dy (mouse +Y is up).
  - Clamp each result: <0 -> 0; >SIZE-1 -> SIZE-1.
  - buttons = {b0[2], b0[1], b0[0]}.
- ready stays 1 throughout streaming; the block never re-enters init except on rst.

Test Plan:
- Normal init: tx_busy=0; respond FA, AA, 00 after the FF pulse, then FA after the F4 pulse -> exactly two tx_start pulses (0xFF then 0xF4); ready=1; err=0.
- Retry/fail with RETRY_MAX=3: respond 0xFE to every FF, or stay silent for TIMEOUT_CYC -> three 0xFF pulses; then err=1, ready=0; further rx produce no tx_start.
- Packet decode from pos (320,240): send 0x09, 0x05, 0x03 -> pos=(325,237), buttons=3'b001, one pkt_valid pulse 2 cycles after the 3rd rx_valid. Then send 0x38, 0xF6, 0xFE -> pos=(315,239), buttons=0.
- Clamp/overflow:
  - From (5,2): send 0x18, 0x80, 0x00 (dx=-128) -> pos_x=0.
  - Send 0x08, 0x00, 0x7F repeatedly -> pos_y saturates at 0.
  - 0x48 with X overflow -> x unchanged.
  - Drive to the right edge -> pos_x=639, never wraps.
- Resync/timeout: in S_B0 send 0x00 (bit3=0) -> discarded. Send 0x08, 0x01, then idle past TIMEOUT_CYC -> no pkt_valid; the next 3 bytes form a correct packet.
- Reset mid-operation: assert rst during WAIT_BAT and again mid-packet -> outputs return to reset values next cycle; init restarts with an 0xFF pulse.
